// File: rtl/bus_arb8_pkg.sv
// Shared types and constants for the eight-way round-robin bus arbiter.
package bus_arb8_pkg;

  localparam int NUM_REQ = 8;
  localparam int SEL_W   = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

endpackage

// File: rtl/bus_arb8_if.sv
// Request/grant bundle between the game sub-units and the arbiter.
// The master side raises requests and the release strobe.
// The slave side (the arbiter) returns the grant, mux select and status.
interface bus_arb8_if;
  import bus_arb8_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic               done;
  logic [NUM_REQ-1:0] gnt;
  logic [SEL_W-1:0]   sel;
  logic               busy;
  logic               timeout;

  modport master (
    output req, done,
    input  gnt, sel, busy, timeout
  );

  modport slave (
    input  req, done,
    output gnt, sel, busy, timeout
  );

endinterface

// File: rtl/bus_arb8_rr_pick8.sv
// Combinational round-robin picker.
// Finds the first set request bit at or after ptr, wrapping mod 8.
module rr_pick8
  import bus_arb8_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [SEL_W-1:0]   ptr_i,
  output logic               any_o,
  output logic [SEL_W-1:0]   idx_o
);

  logic [NUM_REQ-1:0] rot;
  logic [SEL_W-1:0]   off;

  // Rotate right by ptr so the highest-priority requester lands in bit 0.
  assign rot = NUM_REQ'({req_i, req_i} >> ptr_i);

  // Priority-encode the lowest set bit of the rotated vector.
  always_comb begin
    off = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = SEL_W'(i);
    end
  end

  assign any_o = |req_i;
  assign idx_o = ptr_i + off;

endmodule

// File: rtl/bus_arb8.sv
// Round-robin arbiter owning the select of the shared 8:1 bus mux.
// It grants one owner at a time and bounds each tenure to MaxHold cycles
// (0 = unbounded). Every release is followed by one idle turnaround cycle.
module bus_arb8
  import bus_arb8_pkg::*;
#(
  parameter int MaxHold  = 16,
  parameter int CntWidth = 5
) (
  input logic       clk,
  input logic       rst_n,
  bus_arb8_if.slave bus
);

  localparam bit                HoldEn  = (MaxHold != 0);
  localparam logic [CntWidth-1:0] HoldLim = CntWidth'(MaxHold);

  state_e              state_q, state_d;
  logic [SEL_W-1:0]    ptr_q, ptr_d;
  logic [CntWidth-1:0] tenure_q, tenure_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic                busy_q, busy_d;
  logic                timeout_q, timeout_d;

  logic                pickAny;
  logic [SEL_W-1:0]    pickIdx;
  logic                ownerReq;
  logic                atLimit;

  rr_pick8 u_pick (
    .req_i (bus.req),
    .ptr_i (ptr_q),
    .any_o (pickAny),
    .idx_o (pickIdx)
  );

  // During a tenure sel_q always holds the owner's index.
  assign ownerReq = bus.req[sel_q];
  assign atLimit  = HoldEn && (tenure_q == HoldLim);

  // Next-state logic: arbitrate in IDLE, hold or release in GRANT.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    tenure_d  = tenure_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    timeout_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (pickAny) begin
          state_d  = GRANT;
          gnt_d    = {{(NUM_REQ-1){1'b0}}, 1'b1} << pickIdx;
          sel_d    = pickIdx;
          tenure_d = CntWidth'(1);
        end
      end
      GRANT: begin
        if (!ownerReq || bus.done || atLimit) begin
          state_d   = IDLE;
          gnt_d     = '0;
          ptr_d     = sel_q + SEL_W'(1);
          tenure_d  = '0;
          timeout_d = atLimit && ownerReq && !bus.done;
        end else begin
          tenure_d = tenure_q + CntWidth'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase

    busy_d = |gnt_d;
  end

  // State and output registers; reset drops any grant at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      tenure_q  <= '0;
      gnt_q     <= '0;
      sel_q     <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      tenure_q  <= tenure_d;
      gnt_q     <= gnt_d;
      sel_q     <= sel_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.sel     = sel_q;
  assign bus.busy    = busy_q;
  assign bus.timeout = timeout_q;

endmodule

// File: doc/bus_arb8.md
# bus_arb8

Round-robin arbiter sharing one 8:1 bus multiplexer among eight requesters. It grants ownership to one requester at a time and drives the mux select with the owner's index. It enforces a bounded tenure and inserts a one-cycle turnaround gap between owners. It sits between the game sub-units (draw, score, collision, etc.) and the shared display/data bus mux, whose select it owns exclusively.

## Interface
- MaxHold, default 16: maximum consecutive grant cycles per tenure; 0 disables the timeout.
- CntWidth, default 5: tenure counter width; must satisfy MaxHold < 2^CntWidth.
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
- req  input  8  request per requester; bit i = requester i; level-sensitive.
- done  input  1  release strobe from the current owner; ignored while idle.
- gnt  output  8  one-hot grant, registered; all-zero when no owner.
- sel  output  3  binary index of current or last owner, registered; drives the mux select.
- busy  output  1  high while any grant is active; equals OR of gnt.
- timeout  output  1  one-cycle pulse, registered; high in the cycle after a forced revoke.

## Operation
- Two states: IDLE and GRANT.
- Arbitration pointer ptr (3 bits) marks the highest-priority requester. Priority order is ptr, ptr+1, …, ptr+7, all mod 8.
- **IDLE:**
  - If req ≠ 0, select the first set bit in rotated order as owner.
  - Next edge: set gnt = one-hot(owner), sel = owner, tenure = 1, state → GRANT.
  - If req = 0, stay in IDLE. gnt = 0; sel holds its last value.
- **GRANT release condition:** any of
  - req[owner] = 0
  - done = 1
  - MaxHold ≠ 0 and tenure = MaxHold
- **GRANT, release condition true:**
  - Next edge: gnt = 0, state → IDLE, ptr = owner+1 mod 8, sel held, tenure = 0.
- **GRANT, release condition false:** tenure increments and the grant is held.
- **Forced revoke:** timeout is pulsed when the release is caused solely by tenure = MaxHold, with req[owner] still high and done low. If done or a dropped req coincides with the limit, the release counts as normal and timeout stays 0.
- A revoked requester that keeps requesting re-enters arbitration at lowest priority.
- req changes in non-owner bits during GRANT have no effect.
- done asserted in IDLE is ignored.
- **Reset (asynchronous, any time):** state = IDLE, gnt = 0, sel = 0, ptr = 0, tenure = 0, busy = 0, timeout = 0. An in-flight grant is dropped immediately with no gap guarantee.

## Timing
- Grant latency is 1 cycle: req sampled at edge N in IDLE produces gnt/sel valid after edge N.
- Release latency is 1 cycle: a release condition seen at edge M drops gnt after edge M.
- The IDLE cycle after every release is the bus turnaround gap. Minimum owner-to-owner spacing is one cycle with gnt = 0.
- Maximum tenure is exactly MaxHold cycles of gnt high.
- Worst-case wait for a continuously requesting port is 7·(MaxHold+1)+1 cycles.
- sel changes only on the edge where a new grant is issued, so it is stable throughout a tenure and across the gap.
- All outputs come directly from flops; there are no combinational paths from input to output.

## Structure
- Shared package holds:
  - state enum {IDLE, GRANT}
  - constants NUM_REQ = 8 and SEL_W = 3
- Sub-module rr_pick8 (combinational): inputs req[7:0] and ptr[2:0]; outputs any, idx[2:0].
  - Implementation: rotate right by ptr, priority-encode the lowest set bit, add ptr mod 8.
- Top level holds the FSM, ptr, tenure counter and output registers.

## Test plan
- **Reset then single request:** rst_n low, then high; req = 8'h04 → after 1 edge gnt = 8'h04, sel = 2, busy = 1. Drop req → gnt = 0 next cycle, ptr = 3.
- **Round-robin fairness:** req = 8'hFF held, done pulsed at each owner's 2nd cycle → owners 0,1,…,7,0 in order, each followed by exactly one gnt = 0 cycle, sel stable within each tenure.
- **Timeout:** MaxHold = 16, req = 8'h81 held, done = 0 →
  - gnt = 8'h01 for exactly 16 cycles.
  - timeout pulses 1 cycle.
  - After the gap, gnt = 8'h80.
  - Requester 0 is regranted only after requester 7 releases.
- **Coincident release:** at tenure 16 assert done → release with timeout = 0.
  - With MaxHold = 0 and a held req, the grant never times out over 1000 cycles.
- **Pointer priority:** after owner 5 releases (ptr = 6), req = 8'h21 → grant goes to 0 (6, 7 idle, wrap), not 5.
- **Reset mid-tenure:** rst_n low during GRANT with sel = 6 → gnt, busy and sel go to 0 immediately (asynchronous). After release, req = 8'h40 is granted after 1 edge with ptr starting from 0.
